// File: rtl/cordic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_pkg : constants shared by the CORDIC rotation and vectoring engines.
// Rev 1.0
// ---------------------------------------------------------------------------
package cordic_pkg;

   localparam int ATAN_N = 30;

   // Angles are Q3.29 radians; the gain constant is Q1.30.
   localparam logic [31:0] PI      = 32'h6487ED51;
   localparam logic [31:0] HALF_PI = 32'h3243F6A9;
   localparam logic [31:0] K_GAIN  = 32'h26DD3B6A;

   localparam logic [31:0] ATAN_TABLE [ATAN_N] = '{
      32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
      32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
      32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
      32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
      32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
      32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
      32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
      32'h00000002, 32'h00000001
   };

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_ITER = 3'd2,
      ST_POST = 3'd3,
      ST_DONE = 3'd4
   } cordic_state_e;

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_atan_rom : combinational lookup of atan(2^-idx) in Q3.29.
// Rev 1.0
// ---------------------------------------------------------------------------
module cordic_atan_rom
   import cordic_pkg::*;
(
   input  logic [4:0]  idx,
   output logic [31:0] atan
);

   always_comb begin
      atan = '0;
      if (idx < 5'(ATAN_N)) begin
         atan = ATAN_TABLE[idx];
      end
   end

endmodule
`default_nettype wire

// File: rtl/cordic_vector_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_vector_engine : iterative vectoring CORDIC, (x,y) -> atan2 angle and magnitude.
// Option macro CORDIC_GAIN_COMP_EN: scale the magnitude by 1/gain in POST.  Rev 1.0
// ---------------------------------------------------------------------------
module cordic_vector_engine
   import cordic_pkg::*;
#(
   parameter int ITER = 30,
   parameter int IW   = 34
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_x,
   input  logic [31:0] in_y,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] angle_out,
   output logic [31:0] mag_out,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int CW = 5;

   cordic_state_e        state_q, state_d;
   logic [CW-1:0]        iter_q, iter_d;
   logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic                 zero_q, zero_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [31:0]          angle_q, angle_d;
   logic [31:0]          mag_q, mag_d;
   logic [31:0]          atan_val, mag_scaled;
   logic signed [IW-1:0] x_sh, y_sh, atan_ext, half_pi_ext;
   logic                 unused_bits;

   cordic_atan_rom u_atan_rom (
      .idx  (iter_q),
      .atan (atan_val)
   );

   assign x_sh        = x_q >>> iter_q;
   assign y_sh        = y_q >>> iter_q;
   assign atan_ext    = {{(IW-32){1'b0}}, atan_val};
   assign half_pi_ext = {{(IW-32){1'b0}}, HALF_PI};

`ifdef CORDIC_GAIN_COMP_EN
   localparam int PW = IW + 33;
   localparam logic signed [PW-1:0] RND = PW'(2**29);

   logic signed [PW-1:0] prod;

   // Rounded Q1.30 gain correction; x is never negative once the fold has run.
   assign prod        = x_q * $signed({1'b0, K_GAIN}) + RND;
   assign mag_scaled  = prod[61:30];
   assign unused_bits = ^{prod[PW-1:62], prod[29:0], z_q[IW-1:32]};
`else
   assign mag_scaled  = x_q[31:0];
   assign unused_bits = ^{x_q[IW-1:32], z_q[IW-1:32]};
`endif

   always_comb begin
      state_d     = state_q;
      iter_d      = iter_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      angle_d     = angle_q;
      mag_d       = mag_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d        = {{(IW-32){in_x[31]}}, in_x};
               y_d        = {{(IW-32){in_y[31]}}, in_y};
               zero_d     = (in_x == 32'd0) && (in_y == 32'd0);
               in_ready_d = 1'b0;
               state_d    = ST_PRE;
            end
         end
         ST_PRE: begin
            // Left half-plane is rotated by -/+90 degrees so the iterations converge.
            z_d = '0;
            if (x_q[IW-1] && !y_q[IW-1]) begin
               x_d = y_q;
               y_d = -x_q;
               z_d = half_pi_ext;
            end else if (x_q[IW-1] && y_q[IW-1]) begin
               x_d = -y_q;
               y_d = x_q;
               z_d = -half_pi_ext;
            end
            iter_d  = '0;
            state_d = ST_ITER;
         end
         ST_ITER: begin
            if (y_q[IW-1]) begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_ext;
            end else begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_ext;
            end
            if (iter_q == CW'(ITER - 1)) begin
               iter_d  = '0;
               state_d = ST_POST;
            end else begin
               iter_d = iter_q + CW'(1);
            end
         end
         ST_POST: begin
            // A zero vector would otherwise report the sum of all table angles.
            angle_d     = zero_q ? 32'd0 : z_q[31:0];
            mag_d       = zero_q ? 32'd0 : mag_scaled;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         iter_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         angle_q     <= '0;
         mag_q       <= '0;
      end else begin
         state_q     <= state_d;
         iter_q      <= iter_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         angle_q     <= angle_d;
         mag_q       <= mag_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign angle_out = angle_q;
   assign mag_out   = mag_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vector_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cordic_vector_engine : directed vectors scored against a real-arithmetic atan2/hypot model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cordic_vector_engine;

   localparam int ITER_N  = 30;
   localparam int TOL_ANG = 16;
`ifdef CORDIC_GAIN_COMP_EN
   localparam bit          COMP    = 1'b1;
   localparam real         GAIN    = 1.0;
   localparam int          TOL_MAG = 16;
   localparam logic [31:0] MAG_ONE = 32'h40000000;
`else
   localparam bit          COMP    = 1'b0;
   localparam real         GAIN    = 1.6467602581210656;
   localparam int          TOL_MAG = 32;
   // 1.6467602581 * 2^30
   localparam logic [31:0] MAG_ONE = 32'h69648523;
`endif

   typedef struct {
      logic [31:0] ea;
      logic [31:0] em;
      bit          has_la;
      logic [31:0] la;
      bit          has_lm;
      logic [31:0] lm;
      int          hs;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_x, in_y;
   logic        in_valid, in_ready;
   logic [31:0] angle_out, mag_out;
   logic        out_valid, out_ready;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];
   exp_t        cur;
   logic [31:0] hold_ang, hold_mag;
   bit          active;

   cordic_vector_engine #(.ITER(ITER_N), .IW(34)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .angle_out (angle_out),
      .mag_out   (mag_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok, input longint act, input longint req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic bit near(input logic [31:0] a, input logic [31:0] e, input int tol);
      int d;
      d = $signed(a - e);
      return (d >= -tol) && (d <= tol);
   endfunction

   function automatic void model(input logic [31:0] xi, input logic [31:0] yi,
                                 output logic [31:0] ea, output logic [31:0] em);
      real xr, yr, a, m;
      xr = $itor($signed(xi)) / 1073741824.0;
      yr = $itor($signed(yi)) / 1073741824.0;
      a  = (xi == 32'd0 && yi == 32'd0) ? 0.0 : $atan2(yr, xr);
      m  = $sqrt(xr * xr + yr * yr) * GAIN;
      ea = 32'(longint'(a * 536870912.0));
      em = 32'(longint'(m * 1073741824.0));
   endfunction

   task automatic send(input logic [31:0] x, input logic [31:0] y,
                       input bit hla, input logic [31:0] la,
                       input bit hlm, input logic [31:0] lm);
      exp_t e;
      int   n;
      @(negedge clk);
      in_x     = x;
      in_y     = y;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", in_ready == 1'b1, in_ready, 1);
      if (in_ready) begin
         model(x, y, e.ea, e.em);
         e.has_la = hla;
         e.la     = la;
         e.has_lm = hlm;
         e.lm     = lm;
         e.hs     = cyc;
         exp_q.push_back(e);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size() == 0 && !out_valid, exp_q.size(), 0);
   endtask

   // Single compare process: results, latency, stall stability and retention.
   always @(negedge clk) begin
      if (!rst) begin
         hold_ang = '0;
         hold_mag = '0;
         active   = 1'b0;
      end else if (out_valid) begin
         chk("in_ready_low_while_valid", !in_ready, in_ready, 0);
         if (!active) begin
            active = 1'b1;
            chk("result_expected", exp_q.size() != 0, exp_q.size(), 1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               chk("latency", (cyc - cur.hs) == ITER_N + 3, cyc - cur.hs, ITER_N + 3);
               chk("angle_model", near(angle_out, cur.ea, TOL_ANG), angle_out, cur.ea);
               chk("mag_model", near(mag_out, cur.em, TOL_MAG), mag_out, cur.em);
               if (cur.has_la)
                  chk("angle_literal", near(angle_out, cur.la, TOL_ANG), angle_out, cur.la);
               if (cur.has_lm)
                  chk("mag_literal", near(mag_out, cur.lm, TOL_MAG), mag_out, cur.lm);
            end
            hold_ang = angle_out;
            hold_mag = mag_out;
         end else begin
            chk("stall_angle_stable", angle_out == hold_ang, angle_out, hold_ang);
            chk("stall_mag_stable", mag_out == hold_mag, mag_out, hold_mag);
         end
      end else begin
         active = 1'b0;
         chk("retain_angle", angle_out == hold_ang, angle_out, hold_ang);
         chk("retain_mag", mag_out == hold_mag, mag_out, hold_mag);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_in_ready", in_ready == 1'b1, in_ready, 1);
      chk("reset_out_valid", out_valid == 1'b0, out_valid, 0);
      chk("reset_angle", angle_out == 32'd0, angle_out, 0);
      chk("reset_mag", mag_out == 32'd0, mag_out, 0);
      @(posedge clk);
      #2 rst = 1'b1;

      send(32'h40000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, MAG_ONE);
      send(32'h00000000, 32'h40000000, 1'b1, 32'h3243F6A9, 1'b1, MAG_ONE);
      send(32'h00000000, 32'hC0000000, 1'b1, 32'hCDBC0957, 1'b1, MAG_ONE);
      send(32'hC0000000, 32'h00000000, 1'b1, 32'h6487ED51, 1'b1, MAG_ONE);
      send(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 32'h00000000);
      send(32'h20000000, 32'hE0000000, 1'b1, 32'hE6DE04AC, COMP, 32'h2D413CCD);
      send(32'hC0000000, 32'hC0000000, 1'b0, 32'h0, 1'b0, 32'h0);
      send(32'hC0000000, 32'h40000000, 1'b0, 32'h0, 1'b0, 32'h0);
      send(32'h30000000, 32'h10000000, 1'b0, 32'h0, 1'b0, 32'h0);
      send(32'hF0000000, 32'h28000000, 1'b0, 32'h0, 1'b0, 32'h0);
      send(32'h0A000000, 32'hC4000000, 1'b0, 32'h0, 1'b0, 32'h0);
      drain();

      // Backpressure: second request waits until the stalled result is taken.
      out_ready = 1'b0;
      send(32'h2D413CCD, 32'h2D413CCD, 1'b1, 32'h1921FB54, 1'b0, 32'h0);
      fork
         send(32'hE0000000, 32'h30000000, 1'b0, 32'h0, 1'b0, 32'h0);
         begin
            n = 0;
            while (!out_valid && n < 100) begin
               @(negedge clk);
               n++;
            end
            chk("bp_valid_seen", out_valid == 1'b1, out_valid, 1);
            repeat (10) @(negedge clk);
            chk("bp_in_ready_low", in_ready == 1'b0, in_ready, 0);
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset during the iteration phase abandons the operation.
      send(32'h10000000, 32'h30000000, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midreset_out_valid", out_valid == 1'b0, out_valid, 0);
      chk("midreset_in_ready", in_ready == 1'b1, in_ready, 1);
      chk("midreset_angle", angle_out == 32'd0, angle_out, 0);
      chk("midreset_mag", mag_out == 32'd0, mag_out, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      send(32'h40000000, 32'h40000000, 1'b1, 32'h1921FB54, 1'b0, 32'h0);
      send(32'hC0000000, 32'hF0000000, 1'b0, 32'h0, 1'b0, 32'h0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
